// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the F-stage PC and sequences instruction-memory
// requests over a req/ack handshake with redirect and address-error handling.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_F,
    output logic [4:0]  exccode_F
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  exccode_q, exccode_d;

    logic        bad;
    logic        redir;
    logic        req_raw;
    logic [31:0] target;

    assign bad   = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);
    assign redir = req | eret | redirect_valid;

    always_comb begin
        if (req)       target = HANDLER_PC;
        else if (eret) target = epc;
        else           target = redirect_pc;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        exccode_d    = exccode_q;
        req_raw      = 1'b0;
        imem_addr    = pc_q;
        instr_valid  = 1'b0;

        unique case (state_q)
            S_REQ: begin
                req_raw   = !bad;
                imem_addr = pc_q;
                if (redir) begin
                    pc_d = target;
                    // An un-acked request must complete before the new target is fetched.
                    if (!bad && !imem_ack) begin
                        state_d      = S_DRAIN;
                        drain_addr_d = pc_q;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (bad) begin
                    state_d   = S_HOLD;
                    instr_d   = '0;
                    exccode_d = EXC_ADEL;
                end else if (imem_ack) begin
                    state_d   = S_HOLD;
                    instr_d   = imem_rdata;
                    exccode_d = '0;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (redir) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!stall) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                req_raw   = 1'b1;
                imem_addr = drain_addr_q;
                if (redir)    pc_d    = target;
                if (imem_ack) state_d = S_REQ;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Reset gating keeps the bus quiet while reset is held.
    assign imem_req  = req_raw & !reset;
    assign instr     = instr_q;
    assign pc_F      = pc_q;
    assign exccode_F = exccode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            instr_q      <= '0;
            exccode_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            exccode_q    <= exccode_d;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller for the pipelined MIPS core. It owns the F-stage PC register and sequences instruction-memory accesses over a req/ack handshake with variable latency. It applies redirects from the exception unit (handler entry), `eret` (EPC) and the D-stage branch/jump resolver, and flags fetch address errors. It sits between the next-PC/redirect logic and the F/D pipeline register, which it feeds with `instr_valid`/`instr`/`pc_F`/`exccode_F`.

## Interface
- `RESET_PC`, 32'h0000_3000, PC after reset
- `HANDLER_PC`, 32'h0000_4180, exception handler entry
- `IMEM_LO`, 32'h0000_3000, lowest legal fetch address
- `IMEM_HI`, 32'h0000_6ffc, highest legal fetch address
- `EXC_ADEL`, 5'd4, exception code for a fetch address error

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  D stage cannot accept the held instruction
- `req`  in  1  exception/interrupt taken; redirect to `HANDLER_PC`
- `eret`  in  1  return; redirect to `epc`
- `epc`  in  32  return address
- `redirect_valid`  in  1  branch/jump resolved taken
- `redirect_pc`  in  32  branch/jump target
- `imem_req`  out  1  memory request
- `imem_addr`  out  32  request address
- `imem_ack`  in  1  data valid this cycle; completes the request
- `imem_rdata`  in  32  instruction word
- `instr_valid`  out  1  `instr`/`pc_F`/`exccode_F` valid for D
- `instr`  out  32  fetched word; 0 (nop) on address error
- `pc_F`  out  32  address of the presented instruction
- `exccode_F`  out  5  `EXC_ADEL` or 0

## Operation
- Registers:
  - `pc`: next fetch target, which is also `pc_F`
  - `drain_addr`
  - `instr`
  - `exccode_F`
  - state
- States:
  - REQ: fetch `pc`
  - HOLD: present the instruction
  - DRAIN: an abandoned request is in flight
- Address check: `bad = pc[1:0]!=0 || pc<IMEM_LO || pc>IMEM_HI`, unsigned.
- REQ:
  - `imem_req = !bad`, `imem_addr = pc`.
  - If `bad`, the next state is HOLD with `instr<=0` and `exccode_F<=EXC_ADEL`. No memory request is issued.
  - If `imem_ack`, the next state is HOLD with `instr<=imem_rdata` and `exccode_F<=0`.
  - Otherwise the state stays REQ.
- HOLD:
  - `instr_valid=1`.
  - If `!stall`, then `pc<=pc+4` (wraps mod 2^32) and the next state is REQ.
  - If `stall`, all outputs are held.
- DRAIN:
  - `imem_req=1`, `imem_addr=drain_addr`. Returned data is discarded.
  - On `imem_ack`, go to REQ.
- Redirect: `redir = req|eret|redirect_valid`. Target priority is `req` (`HANDLER_PC`) > `eret` (`epc`) > `redirect_pc`.
- A redirect overrides `stall` and `pc+4` in every state. On a redirect, `pc<=target` and `instr_valid` drops the next cycle.
- Next state on a redirect:
  - REQ with an outstanding request (`imem_req=1`) and no `imem_ack`: DRAIN, with `drain_addr<=pc`.
  - REQ with `imem_ack` in the same cycle: data is discarded, next state REQ.
  - REQ with `bad`: next state REQ.
  - HOLD: next state REQ.
  - DRAIN: stay in DRAIN until `imem_ack`. `pc` takes the new target; the latest redirect wins. A redirect coinciding with `imem_ack` in DRAIN goes to REQ with the new target.
- Handshake rule: once `imem_req` rises, `imem_req` and `imem_addr` stay stable until the `imem_ack` cycle inclusive. `imem_ack` while `imem_req=0` is ignored.

## Timing
- Reset, asynchronous:
  - state=REQ, `pc=RESET_PC`, `instr=0`, `exccode_F=0`, `instr_valid=0`, `drain_addr=0`.
  - `imem_req=1` and `imem_addr=RESET_PC` in the first cycle after reset deasserts.
- Reset asserted mid-DRAIN or mid-request aborts immediately. No `imem_req` is driven while reset is high.
- Latency:
  - `imem_ack` in cycle t gives `instr_valid=1` in t+1.
  - HOLD with `!stall` in cycle t gives a new `imem_req` in t+1.
  - Zero-wait memory delivers one instruction per 2 cycles.
- Address error: bad `pc` in REQ at cycle t gives `instr_valid=1`, `instr=0`, `exccode_F=4`, `pc_F`=the bad address in t+1.
- A redirect in cycle t gives `pc_F`/`imem_addr=target` from t+1 when not draining. When draining, the target is used from the cycle after `imem_ack`.
- `imem_req`, `imem_addr` and `instr_valid` are combinational from registered state and `pc` only. There is no input-to-output path.

## Test plan
- Reset, then zero-wait memory returning 0x2408_0001, no stall:
  - `imem_addr` sequence 0x3000, 0x3004, …
  - Each word is presented one cycle after its ack with the matching `pc_F`.
  - `exccode_F=0`.
- Ack delayed 3 cycles and `stall` held 2 cycles in HOLD:
  - `imem_req`/`imem_addr` are stable for all 4 request cycles.
  - `instr` and `pc_F` are held through the stall.
  - The next fetch is 0x3004.
- `redirect_valid=1`, `redirect_pc=0x3100` while a request to 0x3008 is outstanding, with ack 2 cycles later carrying 0xDEADBEEF:
  - DRAIN keeps `imem_addr=0x3008`.
  - 0xDEADBEEF is never presented.
  - The next request is to 0x3100.
- `req`, `eret` (`epc=0x3010`) and `redirect_valid` in the same cycle during a HOLD with `stall`:
  - The next request is to 0x4180.
  - `instr_valid=0` the next cycle.
- `eret` with `epc=0x3002`, then with `epc=0x7000`:
  - No `imem_req` in either case.
  - `instr=0`, `exccode_F=4`, `pc_F`=0x3002 and 0x7000 respectively.
  - A subsequent `req` recovers to 0x4180.
- `reset` asserted mid-DRAIN:
  - Outputs return to reset values immediately.
  - After release, a fresh request to 0x3000; a stray ack during reset is ignored.
